// File: rtl/hazard_pkg.sv
// Shared definitions for the branch-in-decode hazard controller:
// forward-select codes, controller state encoding and the link register.
package hazard_pkg;

    // Decode-stage comparator operand selects.
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file
    localparam logic [1:0] FWD_MEM = 2'b01;  // aluRes_MEM
    localparam logic [1:0] FWD_WB  = 2'b10;  // writeData_WB

    // jal writes the return address here regardless of the destination field.
    localparam logic [4:0] RA_REG = 5'd31;

    // IDLE evaluates hazards; HOLD is the second cycle of a load-to-branch stall.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Destination a stage really writes once jal is taken into account.
    function automatic logic [4:0] eff_dest(input logic jal, input logic [4:0] dest);
        return jal ? RA_REG : dest;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; never wraps.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_clr_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] r_count;

    // Clear wins over increment; at all-ones further events are dropped.
    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX)) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and flush controller for a datapath that resolves branches in decode.
// Produces branch-comparator forward selects, IF/ID stall, IF/ID and ID/EX
// flushes, and counts stall/flush cycles. o_dbg_state exposes the raw FSM
// state register (1 = HOLD) and is not gated by reset.
//
// Handshake note: there is no valid/ready protocol here; every output is a
// same-cycle combinational function of the inputs and the state register.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             Branch_ID,
    input  logic             jr_ID,
    input  logic             jump_ID,
    input  logic             PCSrc_ID,
    input  logic [4:0]       DestReg_EX,
    input  logic [4:0]       DestReg_MEM,
    input  logic [4:0]       writeRegister_WB,
    input  logic             RegWriteEn_EX,
    input  logic             RegWriteEn_MEM,
    input  logic             RegWriteEn_WB,
    input  logic             jal_EX,
    input  logic             jal_MEM,
    input  logic             jal_WB,
    input  logic             MemReadEn_EX,
    input  logic             MemReadEn_MEM,
    output logic [1:0]       ForwardA_branch,
    output logic [1:0]       ForwardB_branch,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             flush_IFID,
    output logic             flush_IDEX,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount,
    output logic             o_dbg_state
);

    // ---------------- destination / producer decode ----------------
    logic [4:0] w_dest_ex, w_dest_mem, w_dest_wb;
    logic       w_prod_ex, w_prod_mem, w_prod_wb;

    assign w_dest_ex  = eff_dest(jal_EX,  DestReg_EX);
    assign w_dest_mem = eff_dest(jal_MEM, DestReg_MEM);
    assign w_dest_wb  = eff_dest(jal_WB,  writeRegister_WB);

    // Writes to r0 are architecturally void, so they never produce a value.
    assign w_prod_ex  = RegWriteEn_EX  && (w_dest_ex  != 5'd0);
    assign w_prod_mem = RegWriteEn_MEM && (w_dest_mem != 5'd0);
    assign w_prod_wb  = RegWriteEn_WB  && (w_dest_wb  != 5'd0);

    // Per-stage register matches; producer status already excludes r0.
    logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt, w_wb_rs, w_wb_rt;

    assign w_ex_rs  = w_prod_ex  && (w_dest_ex  == rs_ID);
    assign w_ex_rt  = w_prod_ex  && (w_dest_ex  == rt_ID);
    assign w_mem_rs = w_prod_mem && (w_dest_mem == rs_ID);
    assign w_mem_rt = w_prod_mem && (w_dest_mem == rt_ID);
    assign w_wb_rs  = w_prod_wb  && (w_dest_wb  == rs_ID);
    assign w_wb_rt  = w_prod_wb  && (w_dest_wb  == rt_ID);

    // Operand use by the decode-stage comparator / jr target.
    logic w_use_rs, w_use_rt;

    assign w_use_rs = Branch_ID || jr_ID;
    assign w_use_rt = Branch_ID;

    // ---------------- branch operand forwarding ----------------
    logic [1:0] w_fwd_a, w_fwd_b;

    // MEM beats WB; a load in MEM has no ALU result yet, so it cannot forward.
    always_comb begin
        w_fwd_a = FWD_RF;
        w_fwd_b = FWD_RF;
        if (rs_ID != 5'd0) begin
            if (w_mem_rs && !MemReadEn_MEM) begin
                w_fwd_a = FWD_MEM;
            end else if (w_wb_rs) begin
                w_fwd_a = FWD_WB;
            end
        end
        if (rt_ID != 5'd0) begin
            if (w_mem_rt && !MemReadEn_MEM) begin
                w_fwd_b = FWD_MEM;
            end else if (w_wb_rt) begin
                w_fwd_b = FWD_WB;
            end
        end
    end

    // ---------------- stall length decode ----------------
    logic w_br_ex, w_br_mem_load, w_load_use_ex;
    logic w_need2, w_need1;

    // Two cycles when the comparator waits on a load still in EX; one cycle
    // for ALU-in-EX, load-in-MEM, or a plain load-use (rs/rt always assumed read).
    always_comb begin
        w_br_ex       = (w_use_rs && w_ex_rs) || (w_use_rt && w_ex_rt);
        w_br_mem_load = MemReadEn_MEM && ((w_use_rs && w_mem_rs) || (w_use_rt && w_mem_rt));
        w_load_use_ex = MemReadEn_EX && (w_ex_rs || w_ex_rt);
        w_need2       = w_br_ex && MemReadEn_EX;
        w_need1       = (w_br_ex && !MemReadEn_EX) || w_br_mem_load || w_load_use_ex;
    end

    // ---------------- stall FSM ----------------
    state_t r_state;
    state_t w_state_nxt;
    logic   w_stall;

    // State register; reset discards any stall still owed from HOLD.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and stall request; detection only matters in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                w_stall = w_need2 || w_need1;
                if (w_need2) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                w_stall     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (!rst) begin
            w_stall     = 1'b0;
            w_state_nxt = IDLE;
        end
    end

    // A held branch redirects only on the cycle it is released.
    logic w_flush;

    assign w_flush = rst && !w_stall && (PCSrc_ID || jump_ID || jr_ID);

    // ---------------- activity counters ----------------
    logic [CNT_W-1:0] w_stall_cnt, w_flush_cnt;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (clk),
        .i_clr_n (rst),
        .i_inc   (w_stall),
        .o_count (w_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (clk),
        .i_clr_n (rst),
        .i_inc   (w_flush),
        .o_count (w_flush_cnt)
    );

    // Output drive; everything reads zero while reset is held.
    always_comb begin
        ForwardA_branch = FWD_RF;
        ForwardB_branch = FWD_RF;
        stall_IF        = 1'b0;
        stall_ID        = 1'b0;
        flush_IDEX      = 1'b0;
        flush_IFID      = 1'b0;
        stallCount      = '0;
        flushCount      = '0;
        if (rst) begin
            ForwardA_branch = w_fwd_a;
            ForwardB_branch = w_fwd_b;
            stall_IF        = w_stall;
            stall_ID        = w_stall;
            flush_IDEX      = w_stall;
            flush_IFID      = w_flush;
            stallCount      = w_stall_cnt;
            flushCount      = w_flush_cnt;
        end
    end

    assign o_dbg_state = (r_state == HOLD);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a per-cycle reference model.
module tb_hazard_ctrl;

  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rs_ID, rt_ID, DestReg_EX, DestReg_MEM, writeRegister_WB;
  logic Branch_ID, jr_ID, jump_ID, PCSrc_ID;
  logic RegWriteEn_EX, RegWriteEn_MEM, RegWriteEn_WB;
  logic jal_EX, jal_MEM, jal_WB, MemReadEn_EX, MemReadEn_MEM;
  logic [1:0] ForwardA_branch, ForwardB_branch;
  logic stall_IF, stall_ID, flush_IFID, flush_IDEX, o_dbg_state;
  logic [CNT_W-1:0] stallCount, flushCount;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rs_ID(rs_ID), .rt_ID(rt_ID),
    .Branch_ID(Branch_ID), .jr_ID(jr_ID), .jump_ID(jump_ID), .PCSrc_ID(PCSrc_ID),
    .DestReg_EX(DestReg_EX), .DestReg_MEM(DestReg_MEM), .writeRegister_WB(writeRegister_WB),
    .RegWriteEn_EX(RegWriteEn_EX), .RegWriteEn_MEM(RegWriteEn_MEM), .RegWriteEn_WB(RegWriteEn_WB),
    .jal_EX(jal_EX), .jal_MEM(jal_MEM), .jal_WB(jal_WB),
    .MemReadEn_EX(MemReadEn_EX), .MemReadEn_MEM(MemReadEn_MEM),
    .ForwardA_branch(ForwardA_branch), .ForwardB_branch(ForwardB_branch),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
    .stallCount(stallCount), .flushCount(flushCount), .o_dbg_state(o_dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model tracks "extra stall cycles still owed" and integer counters.
  int m_owed = 0, m_sc = 0, m_fc = 0;
  int nx_owed = 0, nx_sc = 0, nx_fc = 0;

  function automatic int dest_of(input logic jal, input logic [4:0] d);
    return jal ? 31 : int'(d);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Stall length from the hazard rules, stage by stage.
  function automatic int need_len();
    int n = 0;
    int dex, dmem;
    logic pex, pmem;
    int br_regs[$];
    dex  = dest_of(jal_EX, DestReg_EX);
    dmem = dest_of(jal_MEM, DestReg_MEM);
    pex  = RegWriteEn_EX && (dex != 0);
    pmem = RegWriteEn_MEM && (dmem != 0);
    if (Branch_ID || jr_ID) br_regs.push_back(int'(rs_ID));
    if (Branch_ID)          br_regs.push_back(int'(rt_ID));
    foreach (br_regs[i]) begin
      if (pex && dex == br_regs[i]) n = imax(n, MemReadEn_EX ? 2 : 1);
      if (pmem && MemReadEn_MEM && dmem == br_regs[i]) n = imax(n, 1);
    end
    if (pex && MemReadEn_EX && (dex == int'(rs_ID) || dex == int'(rt_ID))) n = imax(n, 1);
    return n;
  endfunction

  function automatic int fwd_of(input logic [4:0] r);
    int dmem, dwb;
    dmem = dest_of(jal_MEM, DestReg_MEM);
    dwb  = dest_of(jal_WB, writeRegister_WB);
    if (r == 5'd0) return 0;
    if (RegWriteEn_MEM && !MemReadEn_MEM && dmem != 0 && dmem == int'(r)) return 1;
    if (RegWriteEn_WB && dwb != 0 && dwb == int'(r)) return 2;
    return 0;
  endfunction

  // Compare process: every negedge, all outputs against the model.
  always @(negedge clk) begin
    int st, fl, fa, fb, sc, fc;
    if (!rst) begin
      st = 0; fl = 0; fa = 0; fb = 0; sc = 0; fc = 0;
      nx_owed = 0; nx_sc = 0; nx_fc = 0;
    end else begin
      st = (m_owed > 0 || need_len() > 0) ? 1 : 0;
      fl = (st == 0 && (PCSrc_ID || jump_ID || jr_ID)) ? 1 : 0;
      fa = fwd_of(rs_ID);
      fb = fwd_of(rt_ID);
      sc = m_sc;
      fc = m_fc;
      nx_owed = (m_owed > 0) ? m_owed - 1 : ((need_len() == 2) ? 1 : 0);
      nx_sc = (m_sc + st > MAXC) ? MAXC : m_sc + st;
      nx_fc = (m_fc + fl > MAXC) ? MAXC : m_fc + fl;
    end
    check("fwdA", 32'(ForwardA_branch), 32'(fa));
    check("fwdB", 32'(ForwardB_branch), 32'(fb));
    check("stall_IF", 32'(stall_IF), 32'(st));
    check("stall_ID", 32'(stall_ID), 32'(st));
    check("flush_IDEX", 32'(flush_IDEX), 32'(st));
    check("flush_IFID", 32'(flush_IFID), 32'(fl));
    check("stallCount", 32'(stallCount), 32'(sc));
    check("flushCount", 32'(flushCount), 32'(fc));
    check("dbg_state", 32'(o_dbg_state), 32'(m_owed > 0));
  end

  always @(posedge clk) begin
    m_owed = nx_owed;
    m_sc   = nx_sc;
    m_fc   = nx_fc;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    rs_ID = '0; rt_ID = '0; Branch_ID = 0; jr_ID = 0; jump_ID = 0; PCSrc_ID = 0;
    DestReg_EX = '0; DestReg_MEM = '0; writeRegister_WB = '0;
    RegWriteEn_EX = 0; RegWriteEn_MEM = 0; RegWriteEn_WB = 0;
    jal_EX = 0; jal_MEM = 0; jal_WB = 0; MemReadEn_EX = 0; MemReadEn_MEM = 0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic advance();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed vectors ----------------
  initial begin
    clear_inputs();
    advance(); advance();
    settle();
    check("rst stall", 32'(stall_IF), 32'd0);
    check("rst stallCount", 32'(stallCount), 32'd0);
    advance();
    rst = 1'b1;

    // MEM forwarding, no stall
    DestReg_MEM = 5'd5; RegWriteEn_MEM = 1; Branch_ID = 1; rs_ID = 5'd5;
    settle();
    check("lit fwdA mem", 32'(ForwardA_branch), 32'd1);
    check("lit no stall", 32'(stall_IF), 32'd0);
    advance();

    // MEM vs WB priority on rt
    clear_inputs();
    DestReg_MEM = 5'd5; RegWriteEn_MEM = 1; writeRegister_WB = 5'd5; RegWriteEn_WB = 1; rt_ID = 5'd5;
    settle(); check("lit fwdB mem", 32'(ForwardB_branch), 32'd1); advance();
    RegWriteEn_MEM = 0;
    settle(); check("lit fwdB wb", 32'(ForwardB_branch), 32'd2); advance();
    rt_ID = 5'd0;
    settle(); check("lit fwdB r0", 32'(ForwardB_branch), 32'd0); advance();

    // Load in EX feeding a branch: two stall cycles
    clear_inputs();
    DestReg_EX = 5'd8; RegWriteEn_EX = 1; MemReadEn_EX = 1; Branch_ID = 1; rs_ID = 5'd8;
    settle();
    check("lit ld stall1", 32'(stall_IF), 32'd1);
    check("lit ld idex1", 32'(flush_IDEX), 32'd1);
    advance();
    RegWriteEn_EX = 0; MemReadEn_EX = 0; DestReg_EX = '0;
    DestReg_MEM = 5'd8; RegWriteEn_MEM = 1; MemReadEn_MEM = 1;
    settle();
    check("lit ld stall2", 32'(stall_IF), 32'd1);
    check("lit ld idex2", 32'(flush_IDEX), 32'd1);
    advance();
    RegWriteEn_MEM = 0; MemReadEn_MEM = 0; DestReg_MEM = '0;
    writeRegister_WB = 5'd8; RegWriteEn_WB = 1;
    settle();
    check("lit ld fwdA wb", 32'(ForwardA_branch), 32'd2);
    check("lit ld released", 32'(stall_IF), 32'd0);
    check("lit stallCount 2", 32'(stallCount), 32'd2);
    advance();

    // Taken branch, no hazard
    clear_inputs();
    Branch_ID = 1; PCSrc_ID = 1; rs_ID = 5'd1; rt_ID = 5'd2;
    settle(); check("lit flush", 32'(flush_IFID), 32'd1); advance();
    clear_inputs();
    settle();
    check("lit flush one", 32'(flush_IFID), 32'd0);
    check("lit flushCount 1", 32'(flushCount), 32'd1);
    advance();

    // jal in MEM feeding jr r31
    jal_MEM = 1; DestReg_MEM = 5'd0; RegWriteEn_MEM = 1; jr_ID = 1; rs_ID = 5'd31;
    settle();
    check("lit jal fwdA", 32'(ForwardA_branch), 32'd1);
    check("lit jal no stall", 32'(stall_IF), 32'd0);
    advance();

    // EX non-load and MEM load both match: EX rule gives one cycle
    clear_inputs();
    DestReg_EX = 5'd6; RegWriteEn_EX = 1; DestReg_MEM = 5'd6; RegWriteEn_MEM = 1; MemReadEn_MEM = 1;
    Branch_ID = 1; rs_ID = 5'd6;
    settle(); check("lit exmem stall", 32'(stall_IF), 32'd1); advance();
    clear_inputs();
    settle(); check("lit exmem one", 32'(stall_IF), 32'd0); advance();

    // Stall beats flush
    DestReg_EX = 5'd3; RegWriteEn_EX = 1; MemReadEn_EX = 1; Branch_ID = 1; PCSrc_ID = 1; rs_ID = 5'd3;
    settle(); check("lit sbf flush1", 32'(flush_IFID), 32'd0); advance();
    RegWriteEn_EX = 0; MemReadEn_EX = 0; DestReg_EX = '0;
    DestReg_MEM = 5'd3; RegWriteEn_MEM = 1; MemReadEn_MEM = 1;
    settle(); check("lit sbf flush2", 32'(flush_IFID), 32'd0); advance();
    RegWriteEn_MEM = 0; MemReadEn_MEM = 0; DestReg_MEM = '0;
    writeRegister_WB = 5'd3; RegWriteEn_WB = 1;
    settle(); check("lit sbf release", 32'(flush_IFID), 32'd1); advance();

    // Reset while in HOLD
    clear_inputs();
    DestReg_EX = 5'd4; RegWriteEn_EX = 1; MemReadEn_EX = 1; Branch_ID = 1; rs_ID = 5'd4;
    settle(); check("lit pre-hold stall", 32'(stall_IF), 32'd1); advance();
    rst = 1'b0;
    settle();
    check("lit rst hold stall", 32'(stall_IF), 32'd0);
    check("lit rst hold count", 32'(stallCount), 32'd0);
    advance();
    rst = 1'b1;
    clear_inputs();
    settle();
    check("lit post-rst stall", 32'(stall_IF), 32'd0);
    check("lit post-rst state", 32'(o_dbg_state), 32'd0);
    check("lit post-rst count", 32'(stallCount), 32'd0);
    advance();

    // Saturation: stalls from a plain load-use, then flushes from jumps
    DestReg_EX = 5'd7; RegWriteEn_EX = 1; MemReadEn_EX = 1; rs_ID = 5'd7;
    for (int i = 0; i < MAXC + 3; i++) advance();
    clear_inputs();
    settle(); check("lit stall sat", 32'(stallCount), 32'(MAXC)); advance();
    jump_ID = 1;
    for (int i = 0; i < MAXC + 3; i++) advance();
    clear_inputs();
    settle();
    check("lit flush sat", 32'(flushCount), 32'(MAXC));
    check("lit stall still sat", 32'(stallCount), 32'(MAXC));
    advance();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
